// File: rtl/down_counter.sv
// down_counter: synchronous loadable down counter with terminal-count pulse,
// one-shot or auto-reload operation, and IDLE/COUNT/DONE status.
// Optional feature macro: DOWN_COUNTER_PRESCALE_EN. When it is defined, an
// 8-bit prescaler makes a step happen once every PRESCALE enabled cycles.
module down_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] r, r_nx, q_nx;
  logic             tc_nx;
  logic             step;

  // Elaboration guard: the prescaler is 8 bits wide.
  if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
    $error("down_counter: PRESCALE must be in 1..255");
  end

`ifdef DOWN_COUNTER_PRESCALE_EN
  localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

  logic [7:0] p, p_nx;

  // Prescaler: advances on enabled COUNT cycles, wraps on the step cycle.
  always_comb begin
    p_nx = p;
    step = 1'b0;
    if (load) begin
      p_nx = '0;
    end else if (state == COUNT && enable) begin
      if (p == PS_LAST) begin
        step = 1'b1;
        p_nx = '0;
      end else begin
        p_nx = p + 8'd1;
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) p <= '0;
    else        p <= p_nx;
  end
`else
  // Every enabled cycle in COUNT is a step.
  always_comb begin
    step = (state == COUNT) && enable;
  end
`endif

  // Next-state / next-count: load wins, then step; tc defaults low.
  always_comb begin
    state_nx = state;
    q_nx     = Q;
    r_nx     = r;
    tc_nx    = 1'b0;
    if (load) begin
      q_nx     = load_value;
      r_nx     = load_value;
      state_nx = (load_value != '0) ? COUNT : DONE;
    end else if (step) begin
      if (Q == WIDTH'(1)) begin
        q_nx     = '0;
        tc_nx    = 1'b1;
        state_nx = auto_reload ? COUNT : DONE;
      end else if (Q == '0) begin
        // Only reached in auto-reload: the zero cycle restarts the period.
        q_nx = r;
      end else begin
        q_nx = Q - WIDTH'(1);
      end
    end
  end

  // State, count, start value and tc registers.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      Q     <= '0;
      r     <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nx;
      Q     <= q_nx;
      r     <= r_nx;
      tc    <= tc_nx;
    end
  end

  // Status decoded from registered state.
  always_comb begin
    busy = (state == COUNT);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_down_counter.sv
// Testbench for down_counter: directed steps from the test plan followed by a
// randomized phase, all checked against a behavioural model in the bench.
module tb_down_counter;
  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;

  logic             clock = 1'b0;
  logic             clear, load, enable, auto_reload;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] Q;
  logic             tc, busy, done;

  int tests = 0;
  int fails = 0;

  // Reference model: count, start value, pulse, running/finished flags.
  int m_q, m_r, m_tc, m_p;
  bit m_run, m_fin;

  down_counter #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clock(clock), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .auto_reload(auto_reload),
    .Q(Q), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_r = 0; m_tc = 0; m_p = 0; m_run = 0; m_fin = 0;
  endtask

  // Apply one rising edge's worth of behaviour to the model.
  task automatic model_edge();
    bit stepped;
    m_tc = 0;
    if (load) begin
      m_q = int'(load_value); m_r = int'(load_value); m_p = 0;
      m_run = (load_value != 0); m_fin = (load_value == 0);
    end else if (m_run && enable) begin
`ifdef DOWN_COUNTER_PRESCALE_EN
      stepped = (m_p == PRESCALE - 1);
      m_p = stepped ? 0 : m_p + 1;
`else
      stepped = 1;
`endif
      if (stepped) begin
        if (m_q == 0) m_q = m_r;
        else begin
          m_q = m_q - 1;
          if (m_q == 0) begin
            m_tc = 1;
            if (!auto_reload) begin m_run = 0; m_fin = 1; end
          end
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".Q"},    int'(Q),    m_q);
    chk({tag, ".tc"},   int'(tc),   m_tc);
    chk({tag, ".busy"}, int'(busy), int'(m_run));
    chk({tag, ".done"}, int'(done), int'(m_fin));
  endtask

  // One clock: update model from current inputs, then sample 1 after edge.
  task automatic cyc(input string tag);
    model_edge();
    @(posedge clock); #1;
    check_model(tag);
  endtask

  initial begin
    int ar_seq[8];
    ar_seq = '{2, 1, 0, 3, 2, 1, 0, 3};
    clear = 1'b0; load = 1'b0; enable = 1'b0; auto_reload = 1'b0; load_value = '0;
    model_reset();
    #12;
    check_model("por");
    chk("por_Q", int'(Q), 0);
    clear = 1'b1;
    @(posedge clock); #1;

`ifndef DOWN_COUNTER_PRESCALE_EN
    // One-shot from 5.
    load = 1; load_value = 5; auto_reload = 0; enable = 1;
    cyc("os_load"); chk("os_load_Q", int'(Q), 5);
    load = 0;
    for (int i = 4; i >= 0; i--) begin
      cyc("os_run");
      chk("os_Q", int'(Q), i);
      chk("os_tc", int'(tc), (i == 0) ? 1 : 0);
    end
    chk("os_done", int'(done), 1);
    chk("os_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      cyc("os_hold"); chk("os_hold_Q", int'(Q), 0);
    end

    // Auto-reload from 3: period of 4 enabled cycles.
    load = 1; load_value = 3; auto_reload = 1;
    cyc("ar_load"); chk("ar_load_Q", int'(Q), 3);
    load = 0;
    for (int i = 0; i < 8; i++) begin
      cyc("ar_run");
      chk("ar_Q", int'(Q), ar_seq[i]);
      chk("ar_tc", int'(tc), (ar_seq[i] == 0) ? 1 : 0);
      chk("ar_busy", int'(busy), 1);
      chk("ar_done", int'(done), 0);
    end

    // Enable gating, then load overriding enable.
    auto_reload = 0; load = 1; load_value = 9;
    cyc("eg_load");
    load = 0;
    cyc("eg_run"); cyc("eg_run"); chk("eg_Q7", int'(Q), 7);
    enable = 0;
    for (int i = 0; i < 3; i++) begin
      cyc("eg_hold"); chk("eg_hold_Q", int'(Q), 7); chk("eg_hold_tc", int'(tc), 0);
    end
    load = 1; load_value = 12; enable = 1;
    cyc("pri_load"); chk("pri_Q12", int'(Q), 12);
    load = 0;
    cyc("pri_run"); chk("pri_Q11", int'(Q), 11);

    // Zero load goes straight to DONE with no pulse.
    load = 1; load_value = 0;
    cyc("zl_load");
    chk("zl_Q", int'(Q), 0); chk("zl_done", int'(done), 1);
    chk("zl_busy", int'(busy), 0); chk("zl_tc", int'(tc), 0);
    load = 0;
    for (int i = 0; i < 3; i++) begin
      cyc("zl_hold"); chk("zl_hold_tc", int'(tc), 0);
    end
`else
    // Prescaled one-shot from 2: each value lasts PRESCALE cycles.
    load = 1; load_value = 2; auto_reload = 0; enable = 1;
    cyc("ps_load"); chk("ps_load_Q", int'(Q), 2);
    load = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc("ps_run");
      chk("ps_Q", int'(Q), (i < 4) ? 2 : (i < 8) ? 1 : 0);
      chk("ps_tc", int'(tc), (i == 8) ? 1 : 0);
    end
    cyc("ps_after"); chk("ps_after_tc", int'(tc), 0);
`endif

    // Asynchronous clear mid-count, then stays IDLE without load.
    load = 1; load_value = 9; auto_reload = 0; enable = 1;
    cyc("rs_load");
    load = 0;
    while (int'(Q) != 6 && tests < 5000) cyc("rs_run");
    chk("rs_Q6", int'(Q), 6);
    #2 clear = 0;
    model_reset();
    #1;
    chk("rs_Q", int'(Q), 0); chk("rs_tc", int'(tc), 0);
    chk("rs_busy", int'(busy), 0); chk("rs_done", int'(done), 0);
    #2 clear = 1;
    for (int i = 0; i < 5; i++) begin
      cyc("rs_idle"); chk("rs_idle_Q", int'(Q), 0); chk("rs_idle_busy", int'(busy), 0);
    end

    // Randomized traffic against the model, with occasional async clears.
    for (int i = 0; i < 400; i++) begin
      load        = ($urandom_range(0, 9) == 0);
      load_value  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      enable      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) auto_reload = ~auto_reload;
      cyc("rnd");
      if ($urandom_range(0, 60) == 0) begin
        #2 clear = 0;
        model_reset();
        #1 check_model("rnd_clr");
        #2 clear = 1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
